// File: rtl/dmem_responder.sv
// dmem_responder: word memory behind a valid/ready request/response handshake with fixed wait latency
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);
  localparam int W = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic lat_write;
  logic [31:0] lat_addr, lat_wdata;
  logic [31:0] mem [DEPTH_WORDS];
  logic accept, go_resp, acc_write, acc_err;
  logic [31:0] acc_addr, acc_wdata;
  logic [W-1:0] acc_idx;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign busy = state != IDLE;
  assign accept = req_ready && req_valid;
  assign go_resp = (accept && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd0);
  // With zero wait cycles the access lands on the accept edge, before the latches hold the request
  assign acc_write = accept ? req_write : lat_write;
  assign acc_addr = accept ? req_addr : lat_addr;
  assign acc_wdata = accept ? req_wdata : lat_wdata;
  assign acc_err = acc_addr[1:0] != 2'b00 || acc_addr >= 32'(4 * DEPTH_WORDS);
  assign acc_idx = acc_addr[W+1:2];
  // Next-state and wait-counter sequencing
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    if (accept) begin
      state_d = WAIT_CYCLES == 0 ? RESP : WAIT;
      cnt_d = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
    end else if (state == WAIT) begin
      state_d = cnt == 4'd0 ? RESP : WAIT;
      cnt_d = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
    end else if (state == RESP && rsp_ready) begin
      state_d = IDLE;
    end
  end
  // FSM, request latches and registered response; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      lat_write <= 1'b0;
      lat_addr <= 32'd0;
      lat_wdata <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      lat_write <= accept ? req_write : lat_write;
      lat_addr <= accept ? req_addr : lat_addr;
      lat_wdata <= accept ? req_wdata : lat_wdata;
      rsp_rdata <= go_resp ? ((acc_err || acc_write) ? 32'd0 : mem[acc_idx]) : rsp_rdata;
      rsp_err <= go_resp ? acc_err : rsp_err;
    end
  end
  // Storage is never reset; a store commits only on the edge entering RESP and never under reset
  always_ff @(posedge clk) begin
    if (rst && go_resp && acc_write && !acc_err) mem[acc_idx] <= acc_wdata;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized self-checking bench with a word-array reference model
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic b_req_valid = 1'b0, b_req_write = 1'b0, b_rsp_ready = 1'b1;
  logic [31:0] b_req_addr = 32'd0, b_req_wdata = 32'd0;
  logic b_req_ready, b_rsp_valid, b_rsp_err, b_busy;
  logic [31:0] b_rsp_rdata;
  logic [31:0] mem_m [64];
  logic [31:0] mem_z [64];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy)
  );

  function automatic void model(input bit z, input logic w, input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] rd, output logic er);
    er = a[1:0] != 2'b00 || a >= 32'd256;
    rd = 32'd0;
    if (!er && w) begin
      if (z) mem_z[a[7:2]] = d;
      else mem_m[a[7:2]] = d;
    end else if (!er) rd = z ? mem_z[a[7:2]] : mem_m[a[7:2]];
  endfunction

  function automatic logic [31:0] rnd_addr();
    int k = $urandom_range(0, 5);
    if (k == 0) return 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
    if (k == 1) return 32'd256 + 32'($urandom_range(0, 4000)) * 4;
    return 32'($urandom_range(0, 63)) * 4;
  endfunction

  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input int hold,
                      output int lat, output logic [31:0] rd, output logic er, output logic stable,
                      output logic done_ok);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata; er = rsp_err; stable = 1'b1;
    repeat (hold) begin
      req_valid = 1'($urandom); req_addr = $urandom;
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== er || req_ready !== 1'b0) stable = 1'b0;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    done_ok = rsp_valid === 1'b0 && req_ready === 1'b1 && busy === 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_chk++; if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
    n_chk++; if (rsp_err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_err_busy: got %b%b expected 00", rsp_err, busy); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd, erd; logic er, eer, st, ok;
    xact(1'b1, 32'h10, 32'hDEADBEEF, 0, lat, rd, er, st, ok);
    model(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, erd, eer);
    n_chk++; if (lat != 3) begin n_fail++; $display("FAIL store_latency: got %0d expected 3", lat); end
    n_chk++; if (rd !== erd || er !== eer) begin n_fail++; $display("FAIL store_rsp: got %h/%b expected %h/%b", rd, er, erd, eer); end
    xact(1'b0, 32'h10, 32'h0, 0, lat, rd, er, st, ok);
    model(1'b0, 1'b0, 32'h10, 32'h0, erd, eer);
    n_chk++; if (lat != 3) begin n_fail++; $display("FAIL load_latency: got %0d expected 3", lat); end
    n_chk++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_fail++; $display("FAIL load_data: got %h/%b expected deadbeef/0", rd, er); end
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL load_complete: got %b expected 1", ok); end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rd, erd; logic er, eer, st, ok;
    xact(1'b0, 32'h12, 32'h0, 0, lat, rd, er, st, ok);
    n_chk++; if (rd !== 32'd0 || er !== 1'b1) begin n_fail++; $display("FAIL misaligned_rsp: got %h/%b expected 0/1", rd, er); end
    xact(1'b0, 32'h10, 32'h0, 0, lat, rd, er, st, ok);
    model(1'b0, 1'b0, 32'h10, 32'h0, erd, eer);
    n_chk++; if (rd !== erd || er !== eer) begin n_fail++; $display("FAIL misaligned_after: got %h/%b expected %h/%b", rd, er, erd, eer); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd, erd; logic er, eer, st, ok;
    xact(1'b1, 32'h0, 32'h55, 0, lat, rd, er, st, ok);
    model(1'b0, 1'b1, 32'h0, 32'h55, erd, eer);
    xact(1'b1, 32'h100, 32'h1, 0, lat, rd, er, st, ok);
    n_chk++; if (rd !== 32'd0 || er !== 1'b1) begin n_fail++; $display("FAIL oor_store_rsp: got %h/%b expected 0/1", rd, er); end
    xact(1'b0, 32'h0, 32'h0, 0, lat, rd, er, st, ok);
    n_chk++; if (rd !== 32'h55 || er !== 1'b0) begin n_fail++; $display("FAIL oor_word0: got %h/%b expected 55/0", rd, er); end
  endtask

  task automatic test_hold();
    int lat; logic [31:0] rd, erd; logic er, eer, st, ok;
    xact(1'b1, 32'h40, 32'hC0FFEE01, 0, lat, rd, er, st, ok);
    model(1'b0, 1'b1, 32'h40, 32'hC0FFEE01, erd, eer);
    xact(1'b0, 32'h40, 32'h0, 5, lat, rd, er, st, ok);
    n_chk++; if (st !== 1'b1) begin n_fail++; $display("FAIL hold_stable: got %b expected 1", st); end
    n_chk++; if (rd !== 32'hC0FFEE01 || er !== 1'b0) begin n_fail++; $display("FAIL hold_data: got %h/%b expected c0ffee01/0", rd, er); end
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL hold_complete: got %b expected 1", ok); end
  endtask

  task automatic test_abort();
    int lat; logic [31:0] rd, erd; logic er, eer, st, ok;
    xact(1'b1, 32'h20, 32'h12345678, 0, lat, rd, er, st, ok);
    model(1'b0, 1'b1, 32'h20, 32'h12345678, erd, eer);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hAAAA5555;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_chk++; if (busy !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b/%b expected 1/0", busy, req_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0)
      begin n_fail++; $display("FAIL abort_outputs: got busy=%b rdy=%b vld=%b err=%b rd=%h expected 0 1 0 0 0", busy, req_ready, rsp_valid, rsp_err, rsp_rdata); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_release_ready: got %b expected 1", req_ready); end
    xact(1'b0, 32'h20, 32'h0, 0, lat, rd, er, st, ok);
    n_chk++; if (rd !== 32'h12345678 || er !== 1'b0) begin n_fail++; $display("FAIL abort_no_commit: got %h/%b expected 12345678/0", rd, er); end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd, erd, a, d; logic er, eer, st, ok, w;
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      xact(1'b1, 32'(i) * 4, d, 0, lat, rd, er, st, ok);
      model(1'b0, 1'b1, 32'(i) * 4, d, erd, eer);
    end
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom); a = rnd_addr(); d = $urandom;
      xact(w, a, d, $urandom_range(0, 3), lat, rd, er, st, ok);
      model(1'b0, w, a, d, erd, eer);
      n_chk++; if (lat != 3) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected 3", i, lat); end
      n_chk++; if (rd !== erd || er !== eer) begin n_fail++; $display("FAIL rand_rsp[%0d] w=%b a=%h: got %h/%b expected %h/%b", i, w, a, rd, er, erd, eer); end
      n_chk++; if (st !== 1'b1 || ok !== 1'b1) begin n_fail++; $display("FAIL rand_handshake[%0d]: got %b%b expected 11", i, st, ok); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] erd, a, d; logic eer, w;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      n_chk++; if (b_req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, b_req_ready); end
      w = i < 8 ? 1'b1 : 1'($urandom);
      a = i < 8 ? 32'(i) * 4 : 32'($urandom_range(0, 7)) * 4 + ($urandom_range(0, 3) == 0 ? 32'd1 : 32'd0);
      d = $urandom;
      b_req_valid = 1'b1; b_req_write = w; b_req_addr = a; b_req_wdata = d;
      @(negedge clk);
      model(1'b1, w, a, d, erd, eer);
      n_chk++; if (b_rsp_valid !== 1'b1 || b_req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_rsp_valid[%0d]: got %b/%b expected 1/0", i, b_rsp_valid, b_req_ready); end
      n_chk++; if (b_rsp_rdata !== erd || b_rsp_err !== eer) begin n_fail++; $display("FAIL b2b_rsp[%0d] w=%b a=%h: got %h/%b expected %h/%b", i, w, a, b_rsp_rdata, b_rsp_err, erd, eer); end
      b_req_write = 1'($urandom); b_req_addr = $urandom; b_req_wdata = $urandom;
    end
    b_req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_misaligned();
    test_out_of_range();
    test_hold();
    test_abort();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
